sbb_profiler: RTL
=================

// Module: sbb_profiler
// PURPOSE
//  Profiles short backward branches (SBBs = candidate loops) for RCA offload. Counts taken SBBs per branch PC in a
//  small fully-associative table. Issues a partial-reconfiguration (PR) request to the PR queue when a loop gets hot.
//  Sits between the branch unit (upstream) and the PR request queue (downstream).
// PARAMETERS
//  NUM_ENTRIES      rca_config::NUM_PROFILER_ENTRIES (4)          table entries
//  MAX_COUNT        rca_config::MAX_TAKEN_COUNT (256)             count saturates at MAX_COUNT-1
//  THRESHOLD        rca_config::TAKEN_COUNT_THRESHOLD (20)        count value that raises a request
//  MAX_OUTSTANDING  rca_config::MAX_INCOMPLETE_PR_REQUESTS (64)   accepted-but-not-done request limit
//  DECAY_PERIOD     1024                                           cycles between decays (decay build only)
// PORTS
//  clk               in   1      clock
//  rst               in   1      async active-high reset
//  br_valid          in   1      resolved branch/jump this cycle
//  br_taken          in   1      branch taken
//  br_pc             in   32     branch instruction PC
//  br_offset         in   21     signed byte offset of target
//  prof_clear        in   1      sync clear of whole table (outstanding counter kept)
//  pr_req_valid      out  1      request available
//  pr_req_ready      in   1      PR queue accepts
//  pr_req_idx        out  IDX_W  entry index, IDX_W=$clog2(NUM_ENTRIES)
//  pr_req_branch_pc  out  32     loop-closing branch PC
//  pr_req_target_pc  out  32     loop start = br_pc + sext(br_offset)
//  pr_done           in   1      one outstanding PR request completed
//  pr_evict          in   1      invalidate entry pr_evict_idx
//  pr_evict_idx      in   IDX_W  entry to invalidate
// BEHAVIOUR
//  Reset: all entries invalid, counts 0, outstanding 0; pr_req_valid=0; pr_req_idx/pc outputs 0.
//  Qualifying event: br_valid & br_taken & SBB_MAX_OFFSET <= br_offset < 0, signed compare. Others are ignored.
//  Entry: valid, branch_pc, target_pc, count[$clog2(MAX_COUNT)-1:0], pending, locked.
//  Hit (valid & branch_pc match): count+1, saturating. Locked entries still count but never re-request.
//  Miss: allocate lowest-index invalid entry. Otherwise replace the unlocked, non-pending entry with the lowest
//    count (tie -> lowest index). New entry count=1. If no candidate exists, drop the event.
//  Updated count == THRESHOLD and not locked: set pending and locked at the same edge.
//    pr_req_valid rises the next cycle (1-cycle latency from the event).
//  Request output: lowest-index pending entry; pr_req_valid = any pending & outstanding < MAX_OUTSTANDING.
//  Outputs are combinational from registered state. They are stable while valid & !ready.
//  Handshake: valid & ready clears that entry's pending and increments outstanding.
//  pr_done decrements outstanding; a decrement at 0 is ignored. Accept and done in the same cycle: net 0.
//  pr_evict clears all fields of the entry. Evict vs hit/alloc on the same entry in the same cycle: evict wins, event
//    dropped. An evict of a pending entry withdraws its request.
//  prof_clear: all entries invalid next cycle; overrides a concurrent event/accept on the same edge. An accept on that
//    edge still counts.
//  At most one event per cycle. The hit/alloc decision uses state before this edge's evict/clear.
// CONFIGURATION
//  SBB_PROFILER_DECAY_EN defined: free-running cycle counter. Every DECAY_PERIOD cycles, all counts shift right by 1.
//    A hit in the same cycle is applied after the halving. Locked/pending flags are unaffected.
//  Not defined: no decay counter; counts only rise or are cleared by replace/evict/clear.
// STRUCTURE
//  rca_config additions: profiler_entry_t struct, PROFILER_IDX_W, PROFILER_COUNT_W.
//  Sub-module sbb_profiler_victim_sel (combinational): valid/locked/pending/count vectors -> victim idx + found flag.
//  Table, outstanding counter and decay counter live in sbb_profiler. The request arbiter is inline priority logic.
// TESTING
//  Reset mid-run with pending entries -> pr_req_valid=0 immediately; table empty; next event allocates idx 0, count 1.
//  20 taken events, pc 0x100, offset -16, ready=1 -> valid high the cycle after the 20th event.
//    idx=0, branch_pc 0x100, target_pc 0x0F0. A 21st event raises no request.
//  Offsets -36, +8, 0, and not-taken -32 -> no allocation. Offset -32 taken -> allocated.
//  4 entries with counts 5,3,7,9; new pc miss -> idx1 replaced, count 1.
//    All 4 locked; miss -> dropped, table unchanged.
//  MAX_OUTSTANDING=1, two entries reach threshold -> idx0 accepted, valid drops.
//    pr_done -> idx1 presented next cycle. Done+accept in the same cycle -> outstanding stays 1.
//  Decay build, DECAY_PERIOD=16, count 9 -> 4 at period boundary. Hit on the same cycle -> 5.

Source files
------------

// File: rtl/sbb_profiler_pkg.sv
// Shared configuration, entry layout and helpers for the short-backward-branch profiler.
package sbb_profiler_pkg;

  localparam int unsigned NUM_PROFILER_ENTRIES       = 4;
  localparam int unsigned MAX_TAKEN_COUNT            = 256;
  localparam int unsigned TAKEN_COUNT_THRESHOLD      = 20;
  localparam int unsigned MAX_INCOMPLETE_PR_REQUESTS = 64;
  localparam int unsigned DEFAULT_DECAY_PERIOD       = 1024;

  localparam int unsigned PROFILER_IDX_W   = $clog2(NUM_PROFILER_ENTRIES);
  localparam int unsigned PROFILER_COUNT_W = $clog2(MAX_TAKEN_COUNT);

  // Most negative byte offset still treated as a short loop.
  localparam logic signed [20:0] SBB_MAX_OFFSET = -21'sd32;

  typedef struct packed {
    logic                        valid;
    logic [31:0]                 branch_pc;
    logic [31:0]                 target_pc;
    logic [PROFILER_COUNT_W-1:0] count;
    logic                        pending;
    logic                        locked;
  } profiler_entry_t;

  function automatic logic is_sbb_offset(input logic [20:0] off);
    return ($signed(off) >= SBB_MAX_OFFSET) && ($signed(off) < 21'sd0);
  endfunction

endpackage

// File: rtl/sbb_profiler_victim_sel.sv
// Replacement victim selection: lowest-count valid entry that is neither locked nor pending,
// ties resolved toward the lowest index.
module sbb_profiler_victim_sel
  import sbb_profiler_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = NUM_PROFILER_ENTRIES,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
  parameter int unsigned COUNT_W     = PROFILER_COUNT_W
) (
  input  logic [NUM_ENTRIES-1:0]              i_valid,
  input  logic [NUM_ENTRIES-1:0]              i_locked,
  input  logic [NUM_ENTRIES-1:0]              i_pending,
  input  logic [NUM_ENTRIES-1:0][COUNT_W-1:0] i_count,
  output logic [IDX_W-1:0]                    o_idx,
  output logic                                o_found
);

  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [COUNT_W-1:0] w_best;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_best  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (i_valid[i] && !i_locked[i] && !i_pending[i] &&
          (!w_found || (i_count[i] < w_best))) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
        w_best  = i_count[i];
      end
    end
  end

  assign o_idx   = w_idx;
  assign o_found = w_found;

endmodule

// File: rtl/sbb_profiler.sv
// Taken short-backward-branch profiler issuing PR requests for hot loops.
// Optional periodic count halving is enabled with `define SBB_PROFILER_DECAY_EN.
module sbb_profiler
  import sbb_profiler_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES     = NUM_PROFILER_ENTRIES,
  parameter int unsigned MAX_COUNT       = MAX_TAKEN_COUNT,
  parameter int unsigned THRESHOLD       = TAKEN_COUNT_THRESHOLD,
  parameter int unsigned MAX_OUTSTANDING = MAX_INCOMPLETE_PR_REQUESTS,
  parameter int unsigned DECAY_PERIOD    = DEFAULT_DECAY_PERIOD,
  localparam int unsigned IDX_W          = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [31:0]      br_pc,
  input  logic [20:0]      br_offset,
  input  logic             prof_clear,
  output logic             pr_req_valid,
  input  logic             pr_req_ready,
  output logic [IDX_W-1:0] pr_req_idx,
  output logic [31:0]      pr_req_branch_pc,
  output logic [31:0]      pr_req_target_pc,
  input  logic             pr_done,
  input  logic             pr_evict,
  input  logic [IDX_W-1:0] pr_evict_idx
);

  localparam int unsigned CW    = PROFILER_COUNT_W;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  profiler_entry_t r_tab [NUM_ENTRIES];
  profiler_entry_t w_tab [NUM_ENTRIES];
  logic [OUT_W-1:0] r_outstanding;

  logic                        w_qual, w_hit, w_free_found, w_vic_found, w_any_pend;
  logic                        w_accept, w_decay, w_ev_en;
  logic [IDX_W-1:0]            w_hit_idx, w_free_idx, w_vic_idx, w_req_idx, w_ev_idx;
  logic [31:0]                 w_target;
  logic [NUM_ENTRIES-1:0]      w_valid_v, w_locked_v, w_pending_v;
  logic [NUM_ENTRIES-1:0][CW-1:0] w_count_v;

  assign w_qual   = br_valid & br_taken & is_sbb_offset(br_offset);
  assign w_target = br_pc + {{11{br_offset[20]}}, br_offset};

  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_any_pend   = 1'b0;
    w_req_idx    = '0;
    w_valid_v    = '0;
    w_locked_v   = '0;
    w_pending_v  = '0;
    w_count_v    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_valid_v[i]   = r_tab[i].valid;
      w_locked_v[i]  = r_tab[i].locked;
      w_pending_v[i] = r_tab[i].pending;
      w_count_v[i]   = r_tab[i].count;
      if (!w_hit && r_tab[i].valid && (r_tab[i].branch_pc == br_pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!w_free_found && !r_tab[i].valid) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (!w_any_pend && r_tab[i].pending) begin
        w_any_pend = 1'b1;
        w_req_idx  = IDX_W'(i);
      end
    end
  end

  sbb_profiler_victim_sel #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W),
    .COUNT_W     (CW)
  ) u_victim_sel (
    .i_valid   (w_valid_v),
    .i_locked  (w_locked_v),
    .i_pending (w_pending_v),
    .i_count   (w_count_v),
    .o_idx     (w_vic_idx),
    .o_found   (w_vic_found)
  );

  assign pr_req_valid     = w_any_pend && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign pr_req_idx       = w_req_idx;
  assign pr_req_branch_pc = w_any_pend ? r_tab[w_req_idx].branch_pc : '0;
  assign pr_req_target_pc = w_any_pend ? r_tab[w_req_idx].target_pc : '0;
  assign w_accept         = pr_req_valid & pr_req_ready;

`ifdef SBB_PROFILER_DECAY_EN
  localparam int unsigned DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [DEC_W-1:0] r_decay_cnt;

  assign w_decay = (r_decay_cnt == DEC_W'(DECAY_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_decay_cnt <= '0;
    else if (w_decay) r_decay_cnt <= '0;
    else              r_decay_cnt <= r_decay_cnt + 1'b1;
  end
`else
  assign w_decay = 1'b0;
`endif

  // Priority order on one edge: decay, event, accept, evict, clear -- later steps override.
  always_comb begin
    w_tab    = r_tab;
    w_ev_en  = 1'b0;
    w_ev_idx = '0;
    if (w_decay) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        w_tab[i].count = w_tab[i].count >> 1;
      end
    end
    if (w_qual) begin
      if (w_hit) begin
        w_ev_en  = 1'b1;
        w_ev_idx = w_hit_idx;
        if (w_tab[w_hit_idx].count != CW'(MAX_COUNT - 1)) begin
          w_tab[w_hit_idx].count = w_tab[w_hit_idx].count + 1'b1;
        end
      end else if (w_free_found || w_vic_found) begin
        w_ev_en  = 1'b1;
        w_ev_idx = w_free_found ? w_free_idx : w_vic_idx;
        w_tab[w_ev_idx] = '{valid: 1'b1, branch_pc: br_pc, target_pc: w_target,
                            count: CW'(1), pending: 1'b0, locked: 1'b0};
      end
      if (w_ev_en && !w_tab[w_ev_idx].locked && (w_tab[w_ev_idx].count == CW'(THRESHOLD))) begin
        w_tab[w_ev_idx].pending = 1'b1;
        w_tab[w_ev_idx].locked  = 1'b1;
      end
    end
    if (w_accept) w_tab[w_req_idx].pending = 1'b0;
    if (pr_evict) w_tab[pr_evict_idx] = '0;
    if (prof_clear) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) w_tab[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_tab[i] <= '0;
    end else begin
      r_tab <= w_tab;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_accept && !pr_done) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_accept && pr_done && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

endmodule
